// File: rtl/lcd_picture_blit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_picture_blit: ILI9486 CASET/PASET/RAMWR header, then a w x h RAM blit |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_picture_blit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24,
  parameter int RD_LAT = 1,
  parameter int OUT565 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [15:0]       i_x,
  input  logic [15:0]       i_y,
  input  logic [15:0]       i_w,
  input  logic [15:0]       i_h,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_stride,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_rd_en,
  input  logic [DATA_W-1:0] i_ram_data,
  output logic [DATA_W-1:0] o_lcd_data,
  output logic              o_lcd_dc,
  output logic              o_lcd_valid,
  input  logic              i_lcd_ready,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_RD   = 3'd2,
    S_WT   = 3'd3,
    S_PX   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_x;
  logic [15:0]       r_y;
  logic [15:0]       r_w;
  logic [15:0]       r_h;
  logic [15:0]       r_col;
  logic [15:0]       r_row;
  logic [ADDR_W-1:0] r_stride;
  logic [ADDR_W-1:0] r_row_base;
  logic [3:0]        r_idx;
  logic [2:0]        r_wt;
  logic [DATA_W-1:0] r_pix;

  logic [DATA_W-1:0] w_pix_in;
  logic [DATA_W-1:0] w_cmd_word;
  logic [7:0]        w_cmd_byte;
  logic              w_cmd_dc;
  logic [15:0]       w_xe;
  logic [15:0]       w_ye;
  logic              w_start_ok;
  logic              w_hs;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_cmd_last;
  logic              w_wt_done;

  assign w_start_ok = (r_state == S_IDLE) & i_start & ~i_abort;
  assign w_hs       = o_lcd_valid & i_lcd_ready;
  assign w_last_col = (r_col == r_w - 16'd1);
  assign w_last_row = (r_row == r_h - 16'd1);
  assign w_cmd_last = (r_idx == 4'd10);
  assign w_wt_done  = (r_wt == 3'(RD_LAT));
  assign w_xe       = r_x + r_w - 16'd1;
  assign w_ye       = r_y + r_h - 16'd1;

  // Header word sequence, indexed by handshake count within S_CMD.
  always_comb begin
    w_cmd_byte = 8'h00;
    w_cmd_dc   = 1'b1;
    case (r_idx)
      4'd0:  begin w_cmd_byte = 8'h2A; w_cmd_dc = 1'b0; end
      4'd1:  w_cmd_byte = r_x[15:8];
      4'd2:  w_cmd_byte = r_x[7:0];
      4'd3:  w_cmd_byte = w_xe[15:8];
      4'd4:  w_cmd_byte = w_xe[7:0];
      4'd5:  begin w_cmd_byte = 8'h2B; w_cmd_dc = 1'b0; end
      4'd6:  w_cmd_byte = r_y[15:8];
      4'd7:  w_cmd_byte = r_y[7:0];
      4'd8:  w_cmd_byte = w_ye[15:8];
      4'd9:  w_cmd_byte = w_ye[7:0];
      4'd10: begin w_cmd_byte = 8'h2C; w_cmd_dc = 1'b0; end
      default: begin w_cmd_byte = 8'h00; w_cmd_dc = 1'b1; end
    endcase
  end

  assign w_cmd_word = {{(DATA_W-8){1'b0}}, w_cmd_byte};

  generate
    if (OUT565 != 0) begin : g_pack565
      logic [23:0] w_rgb;
      assign w_rgb    = 24'(i_ram_data);
      assign w_pix_in = DATA_W'({w_rgb[23:19], w_rgb[15:10], w_rgb[7:3]});
    end else begin : g_pass
      assign w_pix_in = i_ram_data;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_lcd_valid = 1'b0;
    o_lcd_dc    = 1'b0;
    o_lcd_data  = r_pix;
    o_ram_rd_en = 1'b0;
    o_ram_addr  = '0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_next = ((i_w == 16'd0) || (i_h == 16'd0)) ? S_FIN : S_CMD;
        end
      end
      S_CMD: begin
        o_busy      = 1'b1;
        o_lcd_valid = 1'b1;
        o_lcd_dc    = w_cmd_dc;
        o_lcd_data  = w_cmd_word;
        if (w_hs && w_cmd_last) w_next = S_RD;
      end
      S_RD: begin
        o_busy      = 1'b1;
        o_ram_rd_en = 1'b1;
        o_ram_addr  = r_row_base + ADDR_W'(r_col);
        w_next      = S_WT;
      end
      S_WT: begin
        o_busy = 1'b1;
        if (w_wt_done) w_next = S_PX;
      end
      S_PX: begin
        o_busy      = 1'b1;
        o_lcd_valid = 1'b1;
        o_lcd_dc    = 1'b1;
        if (w_hs) w_next = (w_last_col && w_last_row) ? S_FIN : S_RD;
      end
      S_FIN: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort overrides everything; any read in flight is simply never captured.
    if (i_abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_stride   <= '0;
      r_row_base <= '0;
      r_idx      <= '0;
      r_wt       <= '0;
      r_pix      <= '0;
    end else begin
      if (w_start_ok) begin
        r_x        <= i_x;
        r_y        <= i_y;
        r_w        <= i_w;
        r_h        <= i_h;
        r_stride   <= i_stride;
        r_row_base <= i_base_addr;
        r_col      <= '0;
        r_row      <= '0;
        r_idx      <= '0;
        r_wt       <= '0;
      end
      if ((r_state == S_CMD) && w_hs) r_idx <= r_idx + 4'd1;
      if (r_state == S_RD) begin
        r_wt <= 3'd1;
      end else if (r_state == S_WT) begin
        r_wt <= r_wt + 3'd1;
      end
      if ((r_state == S_WT) && w_wt_done) r_pix <= w_pix_in;
      if ((r_state == S_PX) && w_hs && !i_abort) begin
        if (w_last_col) begin
          r_col      <= '0;
          r_row      <= r_row + 16'd1;
          r_row_base <= r_row_base + r_stride;
        end else begin
          r_col <= r_col + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_picture_blit.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench: two instances (RD_LAT=3 pass-through, RD_LAT=1 RGB565)
// share stimulus; a window model fills expected queues, negedge monitors drain them.
module tb_lcd_picture_blit;
  localparam int AW    = 16;
  localparam int DW    = 24;
  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  typedef struct packed {
    logic          px;
    logic          dc;
    logic [DW-1:0] d;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start, abort;
  logic [15:0]   x, y, w, h;
  logic [AW-1:0] base, stride;

  logic [AW-1:0] a_addr, b_addr;
  logic          a_rd, b_rd;
  logic [DW-1:0] a_rdata, b_rdata, a_data, b_data;
  logic          a_dc, a_valid, a_busy, a_done;
  logic          b_dc, b_valid, b_busy, b_done;
  logic          a_ready = 1'b0;
  int            rdy_mode = 1;

  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] a_pipe [LAT_A];
  logic [DW-1:0] b_pipe [LAT_B];

  word_t         qa[$], qb[$];
  logic [AW-1:0] qaa[$], qba[$];

  int checks = 0, failures = 0;
  int cyc = 0;
  int a_px_cnt = 0, a_done_cnt = 0, b_done_cnt = 0;

  lcd_picture_blit #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_A), .OUT565(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_x(x), .i_y(y), .i_w(w), .i_h(h), .i_base_addr(base), .i_stride(stride),
    .o_ram_addr(a_addr), .o_ram_rd_en(a_rd), .i_ram_data(a_rdata),
    .o_lcd_data(a_data), .o_lcd_dc(a_dc), .o_lcd_valid(a_valid), .i_lcd_ready(a_ready),
    .o_busy(a_busy), .o_done(a_done)
  );

  lcd_picture_blit #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_B), .OUT565(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_x(x), .i_y(y), .i_w(w), .i_h(h), .i_base_addr(base), .i_stride(stride),
    .o_ram_addr(b_addr), .o_ram_rd_en(b_rd), .i_ram_data(b_rdata),
    .o_lcd_data(b_data), .o_lcd_dc(b_dc), .o_lcd_valid(b_valid), .i_lcd_ready(1'b1),
    .o_busy(b_busy), .o_done(b_done)
  );

  // RAM models: data appears exactly RD_LAT cycles after the read, junk otherwise.
  always @(posedge clk) begin
    a_pipe[0] <= a_rd ? mem[a_addr] : DW'($urandom);
    for (int i = 1; i < LAT_A; i++) a_pipe[i] <= a_pipe[i-1];
    b_pipe[0] <= b_rd ? mem[b_addr] : DW'($urandom);
    for (int i = 1; i < LAT_B; i++) b_pipe[i] <= b_pipe[i-1];
    cyc <= cyc + 1;
  end
  assign a_rdata = a_pipe[LAT_A-1];
  assign b_rdata = b_pipe[LAT_B-1];

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       a_ready = 1'b0;
      1:       a_ready = 1'b1;
      default: a_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string info);
    checks++;
    failures++;
    $display("FAIL %s %s", nm, info);
  endtask

  function automatic logic [DW-1:0] pack565(input logic [DW-1:0] d);
    return DW'({d[23:19], d[15:10], d[7:3]});
  endfunction

  task automatic flush();
    qa.delete(); qb.delete(); qaa.delete(); qba.delete();
  endtask

  // Window model: header bytes, then pixels in raster order from base + r*stride + c.
  task automatic push_exp(input logic [15:0] ix, iy, iw, ih, input logic [AW-1:0] ib, is);
    logic [15:0]   xe, ye;
    logic [AW-1:0] ad;
    logic [7:0]    hdr [11];
    logic          hdc [11];
    if (iw == 0 || ih == 0) return;
    xe  = ix + iw - 16'd1;
    ye  = iy + ih - 16'd1;
    hdr = '{8'h2A, ix[15:8], ix[7:0], xe[15:8], xe[7:0],
            8'h2B, iy[15:8], iy[7:0], ye[15:8], ye[7:0], 8'h2C};
    hdc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 11; k++) begin
      qa.push_back('{1'b0, hdc[k], DW'(hdr[k])});
      qb.push_back('{1'b0, hdc[k], DW'(hdr[k])});
    end
    for (int r = 0; r < int'(ih); r++) begin
      for (int c = 0; c < int'(iw); c++) begin
        ad = AW'(int'(ib) + r * int'(is) + c);
        qaa.push_back(ad);
        qba.push_back(ad);
        qa.push_back('{1'b1, 1'b1, mem[ad]});
        qb.push_back('{1'b1, 1'b1, pack565(mem[ad])});
      end
    end
  endtask

  bit            a_stall = 0, a_streak = 0, a_prev_px = 0;
  int            a_last_t = 0;
  logic [DW:0]   a_hold;
  always @(negedge clk) begin
    word_t e;
    if (!rst_n) begin
      a_stall   = 0;
      a_prev_px = 0;
    end else begin
      if (a_rd) begin
        if (qaa.size() == 0) fail("a_rd_unexpected", $sformatf("addr=%0h", a_addr));
        else chk("a_addr", 64'(a_addr), 64'(qaa.pop_front()));
      end
      if (a_stall) begin
        chk("a_valid_held", 64'(a_valid), 64'd1);
        chk("a_data_stable", 64'({a_dc, a_data}), 64'(a_hold));
      end
      if (a_valid && !a_ready) a_streak = 0;
      if (a_valid && a_ready && !abort) begin
        if (qa.size() == 0) fail("a_word_unexpected", $sformatf("data=%0h dc=%0d", a_data, a_dc));
        else begin
          e = qa.pop_front();
          chk("a_word", 64'({a_dc, a_data}), 64'({e.dc, e.d}));
          if (e.px) begin
            if (a_prev_px && a_streak) chk("a_px_period", 64'(cyc - a_last_t), 64'(LAT_A + 2));
            a_px_cnt++;
          end
          a_prev_px = e.px;
          a_last_t  = cyc;
          a_streak  = 1;
        end
      end
      a_stall = a_valid && !a_ready && !abort;
      a_hold  = {a_dc, a_data};
      if (a_done) begin
        a_done_cnt++;
        chk("a_done_drained", 64'(qa.size() + qaa.size()), 64'd0);
        chk("a_busy_in_fin", 64'(a_busy), 64'd0);
      end
    end
  end

  bit b_prev_px = 0;
  int b_last_t  = 0;
  always @(negedge clk) begin
    word_t e;
    if (!rst_n) begin
      b_prev_px = 0;
    end else begin
      if (b_rd) begin
        if (qba.size() == 0) fail("b_rd_unexpected", $sformatf("addr=%0h", b_addr));
        else chk("b_addr", 64'(b_addr), 64'(qba.pop_front()));
      end
      if (b_valid && !abort) begin
        if (qb.size() == 0) fail("b_word_unexpected", $sformatf("data=%0h dc=%0d", b_data, b_dc));
        else begin
          e = qb.pop_front();
          chk("b_word", 64'({b_dc, b_data}), 64'({e.dc, e.d}));
          if (e.px && b_prev_px) chk("b_px_period", 64'(cyc - b_last_t), 64'(LAT_B + 2));
          b_prev_px = e.px;
          b_last_t  = cyc;
        end
      end
      if (b_done) begin
        b_done_cnt++;
        chk("b_done_drained", 64'(qb.size() + qba.size()), 64'd0);
      end
    end
  end

  task automatic pulse_start(input logic [15:0] ix, iy, iw, ih, input logic [AW-1:0] ib, is);
    x = ix; y = iy; w = iw; h = ih; base = ib; stride = is;
    push_exp(ix, iy, iw, ih, ib, is);
    a_px_cnt = 0; a_done_cnt = 0; b_done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input logic [15:0] ix, iy, iw, ih, input logic [AW-1:0] ib, is);
    int n;
    pulse_start(ix, iy, iw, ih, ib, is);
    if (iw == 0 || ih == 0) begin
      chk("zero_done_a", 64'(a_done), 64'd1);
      chk("zero_done_b", 64'(b_done), 64'd1);
      chk("zero_quiet", 64'({a_valid, a_rd, a_busy, b_valid, b_rd}), 64'd0);
    end else begin
      chk("busy_after_start", 64'({a_busy, b_busy}), 64'd3);
    end
    n = 0;
    while (!(a_done_cnt > 0 && b_done_cnt > 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        x = 16'($urandom); y = 16'($urandom); w = 16'($urandom); h = 16'($urandom);
        base = AW'($urandom); stride = AW'($urandom);
      end
      start = (n == 3) && a_busy && b_busy;
    end
    start = 1'b0;
    if (n >= 3000) fail("done_timeout", $sformatf("a_done=%0d b_done=%0d", a_done_cnt, b_done_cnt));
    repeat (3) @(posedge clk);
    #1;
    chk("done_once_a", 64'(a_done_cnt), 64'd1);
    chk("done_once_b", 64'(b_done_cnt), 64'd1);
    chk("queues_empty", 64'(qa.size() + qb.size() + qaa.size() + qba.size()), 64'd0);
    flush();
  endtask

  initial begin
    int n;
    start = 0; abort = 0; x = 0; y = 0; w = 0; h = 0; base = 0; stride = 0;
    for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs_a", 64'({a_valid, a_rd, a_busy, a_done, a_dc, a_addr, a_data}), 64'd0);
    chk("rst_outputs_b", 64'({b_valid, b_rd, b_busy, b_done, b_dc, b_addr, b_data}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    rdy_mode = 1;
    run(16'h0010, 16'h0120, 16'd2, 16'd2, AW'($urandom), AW'($urandom_range(0, 500)));
    run(16'h1234, 16'h0042, 16'd3, 16'd2, 16'h0100, 16'd320);
    mem[16'h0300] = 24'hFF8040;
    run(16'd5, 16'd6, 16'd1, 16'd1, 16'h0300, 16'd1);
    run(16'd7, 16'd9, 16'd0, 16'd5, 16'h0040, 16'd8);
    run(16'd7, 16'd9, 16'd4, 16'd0, 16'h0040, 16'd8);
    run(16'hFFFE, 16'hFFFF, 16'd4, 16'd3, 16'hFFFA, 16'd2);

    // start and abort together in IDLE: nothing may start
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (3) begin
      chk("start_abort_idle", 64'({a_busy, a_valid, a_rd, b_busy, b_valid, b_rd}), 64'd0);
      @(posedge clk); #1;
    end

    rdy_mode = 2;
    for (int t = 0; t < 8; t++) begin
      logic [AW-1:0] s;
      s = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(4, 400));
      run(16'($urandom), 16'($urandom), 16'($urandom_range(1, 6)), 16'($urandom_range(1, 5)),
          AW'($urandom), s);
    end

    // abort while the 4th pixel is waiting in PX
    rdy_mode = 1;
    pulse_start(16'd20, 16'd30, 16'd4, 16'd3, 16'h0800, 16'd10);
    n = 0;
    while (a_px_cnt < 3 && n < 1000) begin @(posedge clk); #1; n++; end
    rdy_mode = 0;
    n = 0;
    while (!a_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("abort_reached_px4", 64'({a_valid, a_dc, 32'(a_px_cnt)}), 64'({1'b1, 1'b1, 32'd3}));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_quiet_a", 64'({a_valid, a_rd, a_busy}), 64'd0);
    chk("abort_quiet_b", 64'({b_valid, b_rd, b_busy}), 64'd0);
    flush();
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(a_done_cnt + b_done_cnt), 64'd0);
    rdy_mode = 2;
    run(16'd20, 16'd30, 16'd4, 16'd3, 16'h0800, 16'd10);

    // reset in the middle of a transfer
    pulse_start(16'd1, 16'd2, 16'd5, 16'd5, 16'h2000, 16'd64);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 64'({a_valid, a_rd, a_busy, a_done, b_valid, b_rd, b_busy, b_done}), 64'd0);
    flush();
    a_done_cnt = 0; b_done_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(a_done_cnt + b_done_cnt), 64'd0);
    chk("midrst_idle", 64'({a_busy, b_busy, a_valid, b_valid}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
